// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit for the EX stage.
// MULT/MULTU/DIV/DIVU take 33 cycles: 32 shift-add or restoring-divide
// iterations on magnitudes, followed by one sign-fix/writeback cycle.
// MTHI/MTLO write HI/LO directly in one cycle.
module muldiv_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cancel,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic                done_q, done_d;
  // Datapath state: accumulator pair, latched operand magnitude, sign flags.
  logic [DATA_W-1:0]   acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opnd_q, opnd_d;
  logic                is_div_q, is_div_d, neg_res_q, neg_res_d;
  logic                neg_rem_q, neg_rem_d, div0_q, div0_d;

  // Two's-complement negate when neg is set (operand magnitude / result fix).
  function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v,
                                                 input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*DATA_W-1:0] cond_neg2(input logic [2*DATA_W-1:0] v,
                                                    input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  logic              signed_op;
  logic [DATA_W-1:0] a_mag, b_mag;
  logic [DATA_W:0]   mul_sum, div_shift, div_trial;
  logic [2*DATA_W-1:0] prod_fix;

  assign signed_op = ~op[0];
  assign a_mag     = cond_neg(a, signed_op & a[DATA_W-1]);
  assign b_mag     = cond_neg(b, signed_op & b[DATA_W-1]);
  // One multiplier bit (LSB of acc_lo) per cycle; carry folds into the shift.
  assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
  // Restoring divide: shift next dividend bit into the partial remainder.
  assign div_shift = {acc_hi_q, acc_lo_q[DATA_W-1]};
  assign div_trial = div_shift - {1'b0, opnd_q};
  assign prod_fix  = cond_neg2({acc_hi_q, acc_lo_q}, neg_res_q);

  // Next-state, iteration datapath and HI/LO writeback.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    case (state_q)
      IDLE: begin
        if (start && !cancel) begin
          case (op)
            3'b000, 3'b001, 3'b010, 3'b011: begin
              state_d   = CALC;
              cnt_d     = '0;
              is_div_d  = op[1];
              neg_res_d = signed_op & (a[DATA_W-1] ^ b[DATA_W-1]);
              neg_rem_d = signed_op & a[DATA_W-1];
              div0_d    = (b == '0);
              acc_hi_d  = '0;
              acc_lo_d  = op[1] ? a_mag : b_mag;
              opnd_d    = op[1] ? b_mag : a_mag;
            end
            3'b100:  hi_d = a;
            3'b101:  lo_d = a;
            default: ;
          endcase
        end
      end
      CALC: begin
        if (cancel) begin
          state_d = IDLE;
        end else begin
          if (is_div_q) begin
            acc_hi_d = div_trial[DATA_W] ? div_shift[DATA_W-1:0] : div_trial[DATA_W-1:0];
            acc_lo_d = {acc_lo_q[DATA_W-2:0], ~div_trial[DATA_W]};
          end else begin
            {acc_hi_d, acc_lo_d} = {mul_sum, acc_lo_q[DATA_W-1:1]};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_W - 1)) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!cancel) begin
          done_d = 1'b1;
          if (is_div_q) begin
            lo_d = div0_q ? '1 : cond_neg(acc_lo_q, neg_res_q);
            hi_d = cond_neg(acc_hi_q, neg_rem_q);
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and architectural HI/LO registers, async active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  // Datapath registers; always loaded on start, so no reset needed.
  always_ff @(posedge clk) begin
    acc_hi_q  <= acc_hi_d;
    acc_lo_q  <= acc_lo_d;
    opnd_q    <= opnd_d;
    is_div_q  <= is_div_d;
    neg_res_q <= neg_res_d;
    neg_rem_q <= neg_rem_d;
    div0_q    <= div0_d;
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit: HI/LO results, latency, cancel, reset.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b110;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        cancel = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present an op at the negedge, let edge E0 sample it, then drop start
  // and scramble a/b (operands need not be held).
  task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0; op = 3'b110; a = $urandom; b = $urandom;
  endtask

  // Count cycles busy stays high after E0 (bounded), then check result.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    issue(o, av, bv);
    wait_idle(n);
    check({tag, " latency"}, n, 33);
    check({tag, " done"}, done, 1);
    check({tag, " hi"}, hi, ehi);
    check({tag, " lo"}, lo, elo);
    @(posedge clk); #1;
    check({tag, " done pulse"}, done, 0);
  endtask

  initial begin
    int n;
    #12;
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    @(negedge clk); reset = 1'b1;

    run_op("MULT neg", 3'b000, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("MULTU", 3'b001, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA);
    run_op("MULTU max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("DIV neg", 3'b010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("DIVU", 3'b011, 32'd7, 32'd2, 32'd1, 32'd3);
    run_op("DIV ovf", 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    run_op("DIVU by0", 3'b011, 32'h64, 32'h0, 32'h64, 32'hFFFFFFFF);
    run_op("DIV by0", 3'b010, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFF9, 32'hFFFFFFFF);

    // MTHI then MTLO back to back.
    @(negedge clk); start = 1'b1; op = 3'b100; a = 32'h1234;
    @(posedge clk); #1;
    check("MTHI busy", busy, 0);
    check("MTHI hi", hi, 32'h1234);
    @(negedge clk); op = 3'b101; a = 32'h5678;
    @(posedge clk); #1;
    check("MTLO busy", busy, 0);
    check("MTLO lo", lo, 32'h5678);
    check("MTLO hi kept", hi, 32'h1234);
    check("MTLO done", done, 0);
    start = 1'b0; op = 3'b110;

    // MULT 5*6 cancelled at counter 10.
    issue(3'b000, 32'd5, 32'd6);
    repeat (10) @(posedge clk);
    @(negedge clk); cancel = 1'b1;
    @(posedge clk); #1; cancel = 1'b0;
    check("cancel busy", busy, 0);
    check("cancel done", done, 0);
    check("cancel hi", hi, 32'h1234);
    check("cancel lo", lo, 32'h5678);
    @(posedge clk); #1;
    check("cancel no done", done, 0);

    // Cancel in the same cycle as start: start dropped.
    @(negedge clk); start = 1'b1; cancel = 1'b1; op = 3'b000; a = 32'd2; b = 32'd2;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    check("start+cancel busy", busy, 0);

    // Cancel while in FIX: writeback suppressed.
    issue(3'b001, 32'd9, 32'd9);
    repeat (32) @(posedge clk);
    @(negedge clk); cancel = 1'b1;
    @(posedge clk); #1; cancel = 1'b0;
    check("fix cancel busy", busy, 0);
    check("fix cancel done", done, 0);
    check("fix cancel hi", hi, 32'h1234);
    check("fix cancel lo", lo, 32'h5678);

    // Async reset mid-DIVU at counter 20.
    issue(3'b011, 32'd1000, 32'd3);
    repeat (20) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("async rst hi", hi, 0);
    check("async rst lo", lo, 0);
    check("async rst busy", busy, 0);
    @(negedge clk); reset = 1'b1;
    run_op("DIVU after rst", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14);

    // Start while busy is ignored.
    issue(3'b001, 32'd3, 32'd4);
    repeat (4) @(posedge clk);
    @(negedge clk); start = 1'b1; op = 3'b011; a = 32'd100; b = 32'd7;
    @(posedge clk); #1; start = 1'b0; op = 3'b110;
    wait_idle(n);
    check("busy-start latency", n + 5, 33);
    check("busy-start hi", hi, 0);
    check("busy-start lo", lo, 12);
    @(posedge clk); #1;
    check("busy-start no requeue", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative HI/LO multiply/divide unit in the EX stage, fed by the register-file read operands (rs → a, rt → b) via the ID/EX latch.
- Executes MULT/MULTU/DIV/DIVU over 33 cycles and MTHI/MTLO in one cycle; holds the architectural HI/LO registers.
- busy is used by the hazard unit to stall MFHI/MFLO and any new muldiv instruction.

Parameters:
- DATA_W, 32, operand and HI/LO width (only 32 is verified).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  issue strobe for op/a/b, sampled on rising edge.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 no-op.
- a  in  DATA_W  rs operand (multiplicand/dividend, MTHI/MTLO source).
- b  in  DATA_W  rt operand (multiplier/divisor).
- cancel  in  1  synchronous flush from exception/branch squash.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse when HI/LO receive a MULT/DIV result.
- hi  out  DATA_W  HI register.
- lo  out  DATA_W  LO register.

Behaviour:
- Reset (async, reset=0): state IDLE, hi=0, lo=0, busy=0, done=0, counter=0. Reset mid-operation aborts it immediately.
- States:
  - IDLE: start && !cancel with op 000–011 → CALC; latch |a|, |b| (unsigned ops take raw values); record quotient/product sign and dividend sign; counter=0.
  - CALC: 32 iterations, counter 0..31 → FIX after counter=31.
  - FIX: sign correction; write hi/lo; → IDLE; done=1 on the same edge.
- Multiply: shift-add on 64-bit accumulator {hi_acc, lo_acc}, one multiplier bit per cycle, LSB first. Signed ops negate the 64-bit product in FIX when a and b signs differ.
- Divide: restoring, one quotient bit per cycle, MSB first, 33-bit trial subtract. Signed ops:
  - quotient negated when signs differ;
  - remainder takes dividend sign.
  - lo = quotient, hi = remainder.
- Divide by zero (DIV or DIVU): full latency; lo=32'hFFFFFFFF, hi=a (original operand, unsigned and signed alike).
- 0x80000000 / 0xFFFFFFFF signed: lo=0x80000000, hi=0.
- Latency: start sampled at edge E0 → busy=1 from E0 through E33 (33 cycles). hi/lo/done update at E33; busy=0 and done=1 in the cycle after E33. done is exactly one cycle.
- MTHI/MTLO: start in IDLE writes hi (or lo) = a at the sampling edge. No busy, no done.
- No-op codes: ignored.
- start while busy=1: ignored; no queueing. The hazard unit must not issue, but the block tolerates it.
- cancel:
  - while busy: next edge → IDLE, hi/lo unchanged, busy=0, done=0.
  - same cycle as start in IDLE: start ignored; cancel has priority.
  - during FIX: write suppressed.
- hi/lo change only at reset, MTHI/MTLO, or FIX. Intermediate accumulator never visible on hi/lo.
- a/b need not be held after the start edge.

Test Plan:
- MULT a=0xFFFFFFFE, b=3 → after 33 cycles: hi=0xFFFFFFFF, lo=0xFFFFFFFA, done one cycle, busy 33 cycles.
- MULTU a=0xFFFFFFFE, b=3 → hi=0x00000002, lo=0xFFFFFFFA. Then MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 → lo=3, hi=1. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU a=0x64, b=0 → lo=0xFFFFFFFF, hi=0x64 after full latency.
- MTHI a=0x1234 then MTLO a=0x5678 on back-to-back cycles → hi=0x1234, lo=0x5678, busy never set. Then MULT 5×6 with cancel at CALC counter=10 → busy drops next edge, hi/lo stay 0x1234/0x5678, no done.
- Reset: assert reset at counter=20 of DIVU → hi=lo=0, busy=0 immediately (no clock). New start after release completes correctly. start asserted during busy is ignored (result matches first op only).
